// File: rtl/shared_acc_pkg.sv
// Shared types and defaults for the shared accumulator arbiter.
// Optional macro SHARED_ACC_SATURATE_EN (used in the top) selects saturating adds.
package shared_acc_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_APPLY = 2'b10
    } state_t;

    localparam logic OP_LOAD = 1'b0;
    localparam logic OP_ADD  = 1'b1;

    function automatic int ptr_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shared_acc_arbiter_rr_pick.sv
// Combinational round-robin search: first set req bit starting at ptr+1, wrapping.
module rr_pick
    import shared_acc_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int PTR_W   = ptr_width(DEF_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [PTR_W-1:0]   winner,
    output logic               valid
);

    always_comb begin
        logic [PTR_W-1:0] w_idx;
        winner = '0;
        valid  = 1'b0;
        w_idx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (!valid && req[w_idx]) begin
                valid  = 1'b1;
                winner = w_idx;
            end
        end
    end

endmodule

// File: rtl/shared_acc_arbiter.sv
// Round-robin arbiter feeding one shared accumulator (load/add) with sticky overflow.
// Define SHARED_ACC_SATURATE_EN to make overflowing adds saturate instead of wrap.
module shared_acc_arbiter
    import shared_acc_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        op,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    input  logic                      clr,
    input  logic                      hold,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [DATA_W-1:0]         acc_out,
    output logic                      ovf,
    output logic                      busy
);

    localparam int PTR_W = ptr_width(NUM_REQ);

    state_t             r_state;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_winner;
    logic [DATA_W-1:0]  r_acc;
    logic [DATA_W-1:0]  r_operand;
    logic               r_op;
    logic               r_ovf;

    logic [PTR_W-1:0]   w_pick_winner;
    logic               w_pick_valid;
    logic [DATA_W-1:0]  w_wdata [NUM_REQ];
    logic               w_req_win;
    logic [DATA_W:0]    w_sum;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req    (req),
        .ptr    (r_ptr),
        .winner (w_pick_winner),
        .valid  (w_pick_valid)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign w_wdata[gi] = wdata[gi*DATA_W +: DATA_W];
            // Pulse only while the winner still requests; a dropped request yields no grant.
            assign gnt[gi] = (r_state == ST_GRANT) && (r_winner == PTR_W'(gi)) && req[gi];
        end
    endgenerate

    assign w_req_win = req[r_winner];
    assign w_sum     = {1'b0, r_acc} + {1'b0, r_operand};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_winner  <= '0;
            r_acc     <= '0;
            r_operand <= '0;
            r_op      <= OP_LOAD;
            r_ovf     <= 1'b0;
        end else if (clr) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!hold && w_pick_valid) begin
                        r_winner <= w_pick_winner;
                        r_state  <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (w_req_win) begin
                        r_op      <= op[r_winner];
                        r_operand <= w_wdata[r_winner];
                        r_state   <= ST_APPLY;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_APPLY: begin
                    if (r_op == OP_ADD) begin
                        if (w_sum[DATA_W]) begin
                            r_ovf <= 1'b1;
`ifdef SHARED_ACC_SATURATE_EN
                            r_acc <= '1;
`else
                            r_acc <= w_sum[DATA_W-1:0];
`endif
                        end else begin
                            r_acc <= w_sum[DATA_W-1:0];
                        end
                    end else begin
                        r_acc <= r_operand;
                    end
                    r_ptr   <= r_winner;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign acc_out = r_acc;
    assign ovf     = r_ovf;
    assign busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_shared_acc_arbiter.sv
// Scoreboard bench for shared_acc_arbiter: stimulus queues expected grants, a monitor checks them.
module tb_shared_acc_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  op;
    logic [15:0] wdata;
    logic        clr;
    logic        hold;
    logic [3:0]  gnt;
    logic [3:0]  acc_out;
    logic        ovf;
    logic        busy;

    shared_acc_arbiter #(.NUM_REQ(4), .DATA_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .op      (op),
        .wdata   (wdata),
        .clr     (clr),
        .hold    (hold),
        .gnt     (gnt),
        .acc_out (acc_out),
        .ovf     (ovf),
        .busy    (busy)
    );

    typedef struct {
        logic [3:0] g;
        logic [3:0] acc;
        logic       ovf;
        int         gap;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   last_grant_cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_txn(input logic [3:0] g, input logic [3:0] a, input logic o, input int gap);
        exp_t e;
        e.g = g; e.acc = a; e.ovf = o; e.gap = gap;
        exp_q.push_back(e);
    endtask

    // Requests held through GRANT, dropped during APPLY; returns with the block back in IDLE.
    task automatic txn(input logic [3:0] r, input logic [3:0] o, input logic [15:0] wd);
        req = r; op = o; wdata = wd;
        tick(2);
        req = '0;
        tick(1);
    endtask

    // Monitor: every grant pops one expectation; acc/ovf are checked two cycles later.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (gnt !== 4'b0000) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_gnt", {28'd0, gnt}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    $display("txn @%0d gnt=%b exp_acc=%h exp_ovf=%b", cyc, gnt, e.acc, e.ovf);
                    chk("gnt", {28'd0, gnt}, {28'd0, e.g});
                    if (e.gap != 0) chk("gnt_spacing", cyc - last_grant_cyc, e.gap);
                    last_grant_cyc = cyc;
                    @(negedge clk);
                    @(negedge clk);
                    chk("acc_out", {28'd0, acc_out}, {28'd0, e.acc});
                    chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; req = '0; op = '0; wdata = '0; clr = 1'b0; hold = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", {28'd0, gnt}, 32'd0);
        chk("rst_acc", {28'd0, acc_out}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Load 9 by requester 2
        expect_txn(4'b0100, 4'h9, 1'b0, 0);
        txn(4'b0100, 4'b0000, 16'h0900);
        tick(1);

        // All requesting continuously from ptr=0: order 1,2,3,0,1 every 3 cycles
        rst_n = 1'b0; tick(1); rst_n = 1'b1;
        expect_txn(4'b0010, 4'hB, 1'b0, 0);
        expect_txn(4'b0100, 4'hC, 1'b0, 3);
        expect_txn(4'b1000, 4'hD, 1'b0, 3);
        expect_txn(4'b0001, 4'hA, 1'b0, 3);
        expect_txn(4'b0010, 4'hB, 1'b0, 3);
        req = 4'b1111; op = 4'b0000; wdata = 16'hDCBA;
        tick(14);
        req = '0;
        tick(2);

        // Overflow: C + 6, then a load keeps ovf sticky
        expect_txn(4'b0001, 4'hC, 1'b0, 0);
        txn(4'b0001, 4'b0000, 16'h000C);
`ifdef SHARED_ACC_SATURATE_EN
        expect_txn(4'b1000, 4'hF, 1'b1, 0);
`else
        expect_txn(4'b1000, 4'h2, 1'b1, 0);
`endif
        txn(4'b1000, 4'b1000, 16'h6000);
        expect_txn(4'b0010, 4'h5, 1'b1, 0);
        txn(4'b0010, 4'b0000, 16'h0050);

        // clr during APPLY of an add
        expect_txn(4'b0100, 4'h0, 1'b0, 0);
        req = 4'b0100; op = 4'b0100; wdata = 16'h0300;
        tick(2);
        req = '0; clr = 1'b1;
        tick(1);
        clr = 1'b0;
        @(negedge clk);
        chk("clr_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;

        // ptr left at 1 by the discarded APPLY, so 2 wins over 3
        expect_txn(4'b0100, 4'h7, 1'b0, 0);
        txn(4'b1100, 4'b0000, 16'h8700);

        // req[1] dropped in GRANT: no grant, acc and ptr unchanged
        req = 4'b0010; op = 4'b0000; wdata = 16'h00E0;
        tick(1);
        req = '0;
        tick(3);
        @(negedge clk);
        chk("drop_acc", {28'd0, acc_out}, 32'h7);
        chk("drop_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        expect_txn(4'b1000, 4'h8, 1'b0, 0);
        txn(4'b1100, 4'b0000, 16'h8700);

        // hold blocks arbitration
        hold = 1'b1; req = 4'b0001; op = 4'b0001; wdata = 16'h0001;
        tick(3);
        @(negedge clk);
        chk("hold_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        hold = 1'b0;
        expect_txn(4'b0001, 4'h9, 1'b0, 0);
        txn(4'b0001, 4'b0001, 16'h0001);

        // Reset during GRANT abandons the transaction
        req = 4'b0010; op = 4'b0000; wdata = 16'h00A0;
        tick(1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstg_gnt", {28'd0, gnt}, 32'd0);
        chk("rstg_acc", {28'd0, acc_out}, 32'd0);
        @(posedge clk); #1;
        req = '0;
        tick(1);
        rst_n = 1'b1;
        tick(3);
        @(negedge clk);
        chk("rstg_acc_after", {28'd0, acc_out}, 32'd0);
        chk("rstg_busy_after", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;

        // Fresh ptr=0 after reset: requester 1 wins over 3
        expect_txn(4'b0010, 4'h3, 1'b0, 0);
        txn(4'b1010, 4'b1010, 16'h5030);

        tick(4);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
